// File: rtl/pwm32_core.sv
// Timer/PWM engine behind the APB PWM32 wrapper.
// Double-buffered compares take effect only at period boundaries.
module pwm32_core (
   input  logic        PCLK,
   input  logic        PRESETn,
   input  logic [31:0] PRE,
   input  logic [31:0] TMRCMP1,
   input  logic [31:0] TMRCMP2,
   input  logic        TMREN,
   output logic        PWM,
   output logic        PERIOD_END,
   output logic [31:0] TMR
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t      state, state_nxt;
   logic [31:0] pre_cnt, pre_cnt_nxt;
   logic [31:0] tmr, tmr_nxt;
   logic [31:0] pre_sh, pre_sh_nxt;
   logic [31:0] cmp1_sh, cmp1_sh_nxt;
   logic [31:0] cmp2_sh, cmp2_sh_nxt;
   logic        pwm_nxt, pe_nxt;
   logic        tick;

   always_ff @(posedge PCLK) begin
      if (!PRESETn) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (TMREN)  state_nxt = RUN;
         RUN:  if (!TMREN) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign tick = (pre_cnt == pre_sh);

   // Outside an enabled RUN cycle everything clears and shadows track inputs.
   always_comb begin
      pre_cnt_nxt = '0;
      tmr_nxt     = '0;
      pwm_nxt     = 1'b0;
      pe_nxt      = 1'b0;
      pre_sh_nxt  = PRE;
      cmp1_sh_nxt = TMRCMP1;
      cmp2_sh_nxt = TMRCMP2;
      if (state == RUN && TMREN) begin
         pre_sh_nxt  = pre_sh;
         cmp1_sh_nxt = cmp1_sh;
         cmp2_sh_nxt = cmp2_sh;
         pwm_nxt     = (tmr < cmp2_sh);
         if (tick) begin
            if (tmr == cmp1_sh) begin
               pe_nxt      = 1'b1;
               pre_sh_nxt  = PRE;
               cmp1_sh_nxt = TMRCMP1;
               cmp2_sh_nxt = TMRCMP2;
            end else begin
               tmr_nxt = tmr + 32'd1;
            end
         end else begin
            pre_cnt_nxt = pre_cnt + 32'd1;
            tmr_nxt     = tmr;
         end
      end
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         pre_cnt    <= '0;
         tmr        <= '0;
         pre_sh     <= '0;
         cmp1_sh    <= '0;
         cmp2_sh    <= '0;
         PWM        <= 1'b0;
         PERIOD_END <= 1'b0;
      end else begin
         pre_cnt    <= pre_cnt_nxt;
         tmr        <= tmr_nxt;
         pre_sh     <= pre_sh_nxt;
         cmp1_sh    <= cmp1_sh_nxt;
         cmp2_sh    <= cmp2_sh_nxt;
         PWM        <= pwm_nxt;
         PERIOD_END <= pe_nxt;
      end
   end

   assign TMR = tmr;

endmodule

// File: tb/tb_pwm32_core.sv
// Scoreboard bench for pwm32_core.
// Expected outputs come from a period-position model of the timer.
module tb_pwm32_core;

   logic        PCLK = 1'b0;
   logic        PRESETn = 1'b0;
   logic [31:0] PRE = '0;
   logic [31:0] TMRCMP1 = '0;
   logic [31:0] TMRCMP2 = '0;
   logic        TMREN = 1'b0;
   logic        PWM;
   logic        PERIOD_END;
   logic [31:0] TMR;

   pwm32_core dut (
      .PCLK       (PCLK),
      .PRESETn    (PRESETn),
      .PRE        (PRE),
      .TMRCMP1    (TMRCMP1),
      .TMRCMP2    (TMRCMP2),
      .TMREN      (TMREN),
      .PWM        (PWM),
      .PERIOD_END (PERIOD_END),
      .TMR        (TMR)
   );

   always #5 PCLK = ~PCLK;

   typedef struct {
      logic [31:0] tmr;
      logic        pwm;
      logic        pe;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Model: position within the current period, counted in PCLK cycles.
   bit              m_run = 0;
   longint unsigned m_pos = 0;
   longint unsigned m_pre = 0, m_c1 = 0, m_c2 = 0;

   task automatic step(input bit rstn, input logic [31:0] pre,
                       input logic [31:0] c1, input logic [31:0] c2,
                       input bit en);
      exp_t            e;
      longint unsigned tl, len, cur_t;
      @(negedge PCLK);
      PRESETn = rstn;
      PRE     = pre;
      TMRCMP1 = c1;
      TMRCMP2 = c2;
      TMREN   = en;
      e.tmr = '0;
      e.pwm = 1'b0;
      e.pe  = 1'b0;
      if (!rstn) begin
         m_run = 0;
         m_pos = 0;
      end else if (!m_run) begin
         m_pos = 0;
         if (en) begin
            m_run = 1;
            m_pre = pre;
            m_c1  = c1;
            m_c2  = c2;
         end
      end else if (!en) begin
         m_run = 0;
         m_pos = 0;
      end else begin
         tl    = m_pre + 1;
         len   = tl * (m_c1 + 1);
         cur_t = m_pos / tl;
         e.pwm = (cur_t < m_c2);
         m_pos = m_pos + 1;
         if (m_pos == len) begin
            m_pos = 0;
            e.pe  = 1'b1;
            m_pre = pre;
            m_c1  = c1;
            m_c2  = c2;
         end else begin
            e.tmr = 32'(m_pos / tl);
         end
      end
      exp_q.push_back(e);
   endtask

   task automatic run(input int n, input logic [31:0] pre,
                      input logic [31:0] c1, input logic [31:0] c2,
                      input bit en);
      for (int i = 0; i < n; i++) step(1'b1, pre, c1, c2, en);
   endtask

   // Monitor: one output sample per cycle, compared against the queue head.
   initial begin
      exp_t e;
      forever begin
         @(posedge PCLK);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (TMR !== e.tmr) begin
               n_fail++;
               $display("FAIL tmr at %0t: got %0d want %0d", $time, TMR, e.tmr);
            end
            n_tests++;
            if (PWM !== e.pwm) begin
               n_fail++;
               $display("FAIL pwm at %0t: got %b want %b", $time, PWM, e.pwm);
            end
            n_tests++;
            if (PERIOD_END !== e.pe) begin
               n_fail++;
               $display("FAIL period_end at %0t: got %b want %b",
                        $time, PERIOD_END, e.pe);
            end
         end
      end
   end

   initial begin
      logic [31:0] rp, r1, r2;
      bit          ren, rrst;
      for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 0, 1'b0);
      step(1'b1, 0, 3, 2, 1'b0);
      run(16, 0, 3, 2, 1'b1);
      run(30, 1, 4, 0, 1'b1);
      run(30, 1, 4, 7, 1'b1);
      run(9, 0, 3, 2, 1'b1);
      run(3, 0, 3, 1, 1'b1);
      run(12, 0, 3, 1, 1'b1);
      run(6, 0, 3, 2, 1'b1);
      run(1, 0, 3, 2, 1'b0);
      run(12, 0, 3, 2, 1'b1);
      step(1'b0, 0, 3, 2, 1'b1);
      run(12, 0, 3, 2, 1'b1);
      run(20, 2, 0, 1, 1'b1);
      run(20, 0, 2, 32'h8000_0000, 1'b1);
      run(20, 1, 2, 32'hFFFF_FFFF, 1'b1);
      run(12, 0, 0, 0, 1'b1);
      for (int i = 0; i < 2500; i++) begin
         if (i % 40 == 0) begin
            rp = $urandom_range(0, 3);
            r1 = $urandom_range(0, 6);
            case ($urandom_range(0, 9))
               0:       r2 = 32'hFFFF_FFFF;
               1:       r2 = 32'h8000_0000;
               default: r2 = $urandom_range(0, 8);
            endcase
         end
         if ($urandom_range(0, 15) == 0) r2 = $urandom_range(0, 8);
         ren  = ($urandom_range(0, 29) != 0);
         rrst = ($urandom_range(0, 199) != 0);
         step(rrst, rp, r1, r2, ren);
      end
      @(negedge PCLK);
      @(negedge PCLK);
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pwm32_core.md
# pwm32_core

Timer/PWM engine sitting directly downstream of the APB PWM32 register wrapper. It consumes the wrapper's PRE, TMRCMP1, TMRCMP2 and TMREN outputs and produces a single PWM waveform, a period-end pulse and the live timer count. Double-buffered compare values make register writes glitch-free: they take effect only at period boundaries.

## Interface
Parameters: none; all datapaths are 32 bits.

Clock/reset: one clock; reset is synchronous and active-low.

Ports:
- PCLK  in  1  clock; all state updates on rising edge
- PRESETn  in  1  synchronous active-low reset
- PRE  in  32  prescaler compare; tick every PRE+1 PCLK cycles
- TMRCMP1  in  32  period compare; period = TMRCMP1+1 ticks
- TMRCMP2  in  32  duty compare; PWM high while timer < compare
- TMREN  in  1  run enable, level-sensitive
- PWM  out  1  registered PWM output
- PERIOD_END  out  1  registered one-cycle pulse per completed period
- TMR  out  32  current timer count (registered)

## Operation
- Registers: state (IDLE/RUN), pre_cnt[31:0], tmr[31:0], shadows pre_sh, cmp1_sh, cmp2_sh, PWM, PERIOD_END.
- Reset (PRESETn=0 at an edge): state=IDLE; all counters, shadows, PWM, PERIOD_END and TMR = 0.
- IDLE:
  - pre_cnt=0, tmr=0, PWM=0, PERIOD_END=0.
  - Shadows load from PRE/TMRCMP1/TMRCMP2 every cycle.
  - TMREN=1 → RUN. On that edge the shadows capture the current inputs and counters stay 0.
- RUN, each edge with TMREN=1:
  - tick = (pre_cnt == pre_sh).
  - If tick: pre_cnt←0, else pre_cnt←pre_cnt+1.
  - On tick with tmr == cmp1_sh (wrap):
    - tmr←0.
    - Shadows reload from inputs.
    - PERIOD_END←1.
  - On tick without wrap: tmr←tmr+1, PERIOD_END←0.
  - No tick: tmr holds, PERIOD_END←0.
  - PWM←(tmr < cmp2_sh), using pre-edge register values, unsigned.
- RUN with TMREN=0 at an edge:
  - state←IDLE.
  - pre_cnt, tmr, PWM, PERIOD_END all ← 0 on that same edge.
  - Shadows load inputs.
- Compare semantics, all unsigned 32-bit:
  - cmp2_sh=0 → PWM constantly 0.
  - cmp2_sh > cmp1_sh → PWM constantly 1 while running.
  - cmp1_sh=0 → tmr stays 0 and every tick is a wrap.
  - pre_sh=0 → tick every cycle.
- Counters never exceed their shadow compare, so no arithmetic overflow occurs. tmr wraps at cmp1_sh=32'hFFFFFFFF, i.e. at the natural 32-bit limit.
- Input changes during RUN do not affect the current period. They are applied at the wrap edge that starts the next period.
- TMR output = tmr register.

## Timing
- Enable latency:
  - Edge E0 samples TMREN=1 in IDLE.
  - Edge E0+1 is the first RUN counting edge.
  - PWM first reflects tmr=0 after edge E0+1; the first high cycle, if cmp2_sh>0, follows E0+1.
- PWM lags tmr by exactly one PCLK cycle.
- Period = (pre_sh+1)*(cmp1_sh+1) PCLK cycles.
- High time per period = min(cmp2_sh, cmp1_sh+1)*(pre_sh+1) cycles.
- PERIOD_END is high for exactly one cycle, immediately after the wrap edge, coincident with tmr=0.
- Disable: PWM=0 and TMR=0 in the cycle after TMREN is first sampled low. No partial-period completion.
- Reset has priority over TMREN at any point, mid-period included.

## Test plan
- PRE=0, TMRCMP1=3, TMRCMP2=2, TMREN=1 → PWM repeats 1,1,0,0 (period 4 cycles); PERIOD_END once per 4 cycles; TMR cycles 0..3.
- PRE=1, TMRCMP1=4, TMRCMP2=0 → PWM stays 0; PERIOD_END every 10 cycles. Then change to TMRCMP2=7 → PWM constantly 1 from the next period.
- PRE=0, TMRCMP1=3, TMRCMP2=2 running; write TMRCMP2=1 while tmr=1 → current period keeps 2 high cycles; subsequent periods show 1 high, 3 low.
- Running, drop TMREN while tmr=2 → next cycle PWM=0, TMR=0, PERIOD_END=0. Re-assert TMREN → timing restarts from tmr=0 with the two-edge enable latency.
- Assert PRESETn=0 for one edge mid-period while TMREN=1 → all outputs 0 next cycle. On release with TMREN still 1: IDLE→RUN sequence as on a fresh enable.
- PRE=2, TMRCMP1=0, TMRCMP2=1 → tick every 3 cycles, PERIOD_END every 3 cycles, PWM constantly 1 after enable latency, TMR always 0.
